exp_interval: RTL

- Stage directly downstream of the ln iterator in the Monte Carlo Hawkes datapath.
- Converts a log-uniform sample into an exponential inter-arrival time: tau = -ln(U) / lambda.
- Consumes the signed Q2.8 ln result and the current intensity lambda (unsigned Q2.8).
- Produces tau in unsigned Q8.8 using a sequential restoring divider, one quotient bit per cycle, with a start/done handshake matching the ln stage.

---
 rtl/exp_interval.sv | 109 ++++++++++
 1 files changed

// File: rtl/exp_interval.sv
// Exponential inter-arrival stage: tau = -ln(U) / lambda in Q8.8, computed with
// an 18-step restoring divider behind a start/busy/done handshake.
module exp_interval #(
    parameter int W_IN  = 10,
    parameter int FRAC  = 8,
    parameter int W_OUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W_IN-1:0]   ln_in,
    input  logic [W_IN-1:0]   lambda,
    output logic [W_OUT-1:0]  tau,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic              err
);
    localparam int W_N = W_IN + FRAC;      // dividend / quotient width
    localparam int W_R = W_IN + 1;         // remainder width
    localparam int W_C = $clog2(W_N);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t            r_state;
    logic [W_N-1:0]    r_num;
    logic [W_N-1:0]    r_quo;
    logic [W_IN-1:0]   r_den;
    logic [W_R-1:0]    r_rem;
    logic [W_C-1:0]    r_cnt;

    logic [W_IN-1:0]   w_mag;
    logic [W_R:0]      w_trial;
    logic              w_fit;
    logic [W_R-1:0]    w_diff;
    logic [W_R-1:0]    w_rem_next;
    logic [W_N-1:0]    w_quo_next;

    // Positive ln values are out of domain and clamp to a zero magnitude.
    always_comb begin
        w_mag      = ln_in[W_IN-1] ? (~ln_in + 1'b1) : '0;
        w_trial    = {r_rem, r_num[W_N-1]};
        w_fit      = w_trial >= {{(W_R+1-W_IN){1'b0}}, r_den};
        w_diff     = w_trial[W_R-1:0] - {{(W_R-W_IN){1'b0}}, r_den};
        w_rem_next = w_fit ? w_diff : w_trial[W_R-1:0];
        w_quo_next = {r_quo[W_N-2:0], w_fit};
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_quo   <= '0;
            r_den   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            tau     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        done  <= 1'b0;
                        ovf   <= 1'b0;
                        err   <= 1'b0;
                        r_num <= {w_mag, {FRAC{1'b0}}};
                        r_den <= lambda;
                        r_rem <= '0;
                        r_quo <= '0;
                        r_cnt <= W_C'(W_N - 1);
                        if (lambda == '0) begin
                            r_state <= S_DONE;
                            tau     <= '1;
                            err     <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_DIV;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_num <= {r_num[W_N-2:0], 1'b0};
                    r_cnt <= r_cnt - 1'b1;
                    // Last step: the freshly shifted quotient is final.
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (|w_quo_next[W_N-1:W_OUT]) begin
                            tau <= '1;
                            ovf <= 1'b1;
                        end else begin
                            tau <= w_quo_next[W_OUT-1:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
